// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32 widths, divider op encodings, FSM states and constants.
package rv_pkg;
  localparam int XLEN = 32;
  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} div_state_t;
  localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
endpackage

// File: rtl/div_step.sv
// div_step: one restoring-division step producing one quotient bit.
module div_step import rv_pkg::*; (
  input  logic [XLEN:0]   rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN:0]   rem_o,
  output logic [XLEN-1:0] quo_o
);
  logic [XLEN+1:0] shifted, trial;
  // one guard bit above the 33-bit partial remainder makes the trial sign exact
  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign trial   = shifted - {2'b00, divisor_i};
  assign rem_o   = trial[XLEN+1] ? shifted[XLEN:0] : trial[XLEN:0];
  assign quo_o   = {quo_i[XLEN-2:0], ~trial[XLEN+1]};
endmodule

// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU with registered register-file write-back.
module div_unit import rv_pkg::*; (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr_in,
  output logic            busy,
  output logic            done,
  output logic            wr_en,
  output logic [4:0]      rd_addr,
  output logic [XLEN-1:0] result
);
  div_state_t      state_q;
  logic [1:0]      op_q;
  logic [4:0]      rd_q, cnt_q;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d, divisor_q, result_q;
  logic            neg_quo_q, neg_rem_q, done_q, wr_en_q;
  logic            signed_op, rem_op, rem_sel, s1, s2, div0, ovf;
  logic [XLEN-1:0] mag1, mag2, spec_res, sel, res_d;

  assign signed_op = op == DIV_OP_DIV || op == DIV_OP_REM;
  assign rem_op    = op == DIV_OP_REM || op == DIV_OP_REMU;
  assign s1        = signed_op & rs1_data[XLEN-1];
  assign s2        = signed_op & rs2_data[XLEN-1];
  assign mag1      = s1 ? -rs1_data : rs1_data;
  assign mag2      = s2 ? -rs2_data : rs2_data;
  assign div0      = rs2_data == '0;
  assign ovf       = signed_op && rs1_data == INT_MIN && rs2_data == '1;
  assign spec_res  = div0 ? (rem_op ? rs1_data : DIV_BY_ZERO_Q) : (rem_op ? '0 : INT_MIN);
  assign rem_sel   = op_q == DIV_OP_REM || op_q == DIV_OP_REMU;
  assign sel       = rem_sel ? rem_q[XLEN-1:0] : quo_q;
  assign res_d     = (rem_sel ? neg_rem_q : neg_quo_q) ? -sel : sel;

  div_step u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (divisor_q),
    .rem_o     (rem_d),
    .quo_o     (quo_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      divisor_q <= '0;
      result_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        IDLE: if (start) begin
          op_q      <= op;
          rd_q      <= rd_addr_in;
          divisor_q <= mag2;
          quo_q     <= mag1;
          rem_q     <= '0;
          neg_quo_q <= s1 ^ s2;
          neg_rem_q <= s1;
          cnt_q     <= 5'd31;
          if (div0 || ovf) begin
            result_q <= spec_res;
            done_q   <= 1'b1;
            wr_en_q  <= rd_addr_in != '0;
            state_q  <= DONE;
          end else begin
            state_q  <= CALC;
          end
        end
        CALC: begin
          rem_q   <= rem_d;
          quo_q   <= quo_d;
          cnt_q   <= cnt_q - 5'd1;
          state_q <= cnt_q == '0 ? SIGN : CALC;
        end
        SIGN: begin
          result_q <= res_d;
          done_q   <= 1'b1;
          wr_en_q  <= rd_q != '0;
          state_q  <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy    = state_q != IDLE;
  assign done    = done_q;
  assign wr_en   = wr_en_q;
  assign rd_addr = rd_q;
  assign result  = result_q;
endmodule
